// File: rtl/pt2262_pkg.sv
// PT2262 encoder constants: trit codes, waveform timing, FSM state type.
// Latency: n/a (declarations and one combinational helper only).
// Backpressure: n/a.
package pt2262_pkg;

    // Trit codes as carried in the 24-bit address/data word (2'b11 is sent as float)
    localparam logic [1:0] TRIT_0 = 2'b00;
    localparam logic [1:0] TRIT_1 = 2'b01;
    localparam logic [1:0] TRIT_F = 2'b10;

    localparam int N_TRITS     = 12;
    localparam int BIT_CYCLES  = 32;
    localparam int HALF_CYCLES = 16;
    localparam int SHORT_HI    = 4;
    localparam int LONG_HI     = 12;
    localparam int SYNC_CYCLES = 128;

    typedef enum logic {
        IDLE,
        TX
    } state_t;

    // Trit idx of word w; trit 0 is the most significant pair.
    function automatic logic [1:0] trit_at(input logic [23:0] w, input logic [3:0] idx);
        logic [1:0] t;
        t = TRIT_0;
        for (int i = 0; i < N_TRITS; i++) begin
            if (idx == 4'(i)) begin
                t = w[(2 * (N_TRITS - 1 - i)) +: 2];
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/pt2262_bit_wave.sv
// PT2262 single-bit waveform lookup: output level for a trit (or sync) at a cycle index.
// Latency: purely combinational.
// Backpressure: none.
// Ports: trit (2b code), sync (1 = sync bit, trit ignored), cyc (7b cycle index), level (waveform level).
module pt2262_bit_wave (
    input  logic [1:0] trit,
    input  logic       sync,
    input  logic [6:0] cyc,
    output logic       level
);
    import pt2262_pkg::*;

    logic [6:0] in_half;
    logic       second_half;
    logic [6:0] hi_len;

    // Every code bit is two 16-cycle halves, each starting high; only the
    // length of the high pulse in each half depends on the trit.
    always_comb begin
        in_half     = cyc % 7'(HALF_CYCLES);
        second_half = (cyc >= 7'(HALF_CYCLES));
        hi_len      = 7'(SHORT_HI);
        if (trit == TRIT_1) begin
            hi_len = 7'(LONG_HI);
        end else if ((trit == TRIT_F || trit == 2'b11) && second_half) begin
            hi_len = 7'(LONG_HI);
        end
        if (sync) begin
            level = (cyc < 7'(SHORT_HI));
        end else begin
            level = (in_half < hi_len);
        end
    end

endmodule

// File: rtl/pt2262_encoder.sv
// PT2262 encoder: serialises a latched 12-trit word as 12x32-cycle code bits + 128-cycle sync, repeating.
// Latency: q shows trit 0 cycle 0 one edge after ld is first sampled low; frame period 512 cycles.
// Backpressure: none; ld high stops transmission (q=0) and latches ad. Optional `PT2262_FRAME_DONE_EN adds frame_done.
// Ports: clk, rst (sync active-high), ld (load/hold), ad (24b word, trit 0 = ad[23:22]), q (registered waveform),
//        frame_done (only with PT2262_FRAME_DONE_EN: one-cycle pulse on last sync cycle).
module pt2262_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld,
    input  logic [23:0] ad,
    output logic        q
`ifdef PT2262_FRAME_DONE_EN
    ,
    output logic        frame_done
`endif
);
    import pt2262_pkg::*;

    state_t      state, state_nx;
    logic [3:0]  bit_cnt, bit_nx;
    logic [6:0]  cyc_cnt, cyc_nx;
    logic [23:0] shadow;
    logic        valid;
    logic        q_nx;
    logic        level;
    logic        is_sync;
    logic        last_sync;
    logic        last_bit_cyc;

    pt2262_bit_wave u_wave (
        .trit  (trit_at(shadow, bit_cnt)),
        .sync  (is_sync),
        .cyc   (cyc_cnt),
        .level (level)
    );

`ifdef PT2262_FRAME_DONE_EN
    logic fd_nx;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            cyc_cnt <= '0;
            shadow  <= '0;
            valid   <= 1'b0;
            q       <= 1'b0;
`ifdef PT2262_FRAME_DONE_EN
            frame_done <= 1'b0;
`endif
        end else begin
            state   <= state_nx;
            bit_cnt <= bit_nx;
            cyc_cnt <= cyc_nx;
            q       <= q_nx;
`ifdef PT2262_FRAME_DONE_EN
            frame_done <= fd_nx;
`endif
            if (ld) begin
                shadow <= ad;
                valid  <= 1'b1;
            end
        end
    end

    // Counters point at the cycle whose level is registered into q at the
    // next edge; IDLE keeps them at 0 so the first TX edge emits trit 0, c=0.
    always_comb begin
        state_nx     = state;
        bit_nx       = bit_cnt;
        cyc_nx       = cyc_cnt;
        q_nx         = 1'b0;
        is_sync      = (bit_cnt == 4'(N_TRITS));
        last_sync    = is_sync && (cyc_cnt == 7'(SYNC_CYCLES - 1));
        last_bit_cyc = (cyc_cnt == 7'(BIT_CYCLES - 1));
`ifdef PT2262_FRAME_DONE_EN
        fd_nx        = 1'b0;
`endif
        if (ld) begin
            state_nx = IDLE;
            bit_nx   = '0;
            cyc_nx   = '0;
        end else if (state == TX || valid) begin
            state_nx = TX;
            q_nx     = level;
`ifdef PT2262_FRAME_DONE_EN
            fd_nx    = last_sync;
`endif
            if (last_sync) begin
                bit_nx = '0;
                cyc_nx = '0;
            end else if (!is_sync && last_bit_cyc) begin
                bit_nx = bit_cnt + 4'd1;
                cyc_nx = '0;
            end else begin
                cyc_nx = cyc_cnt + 7'd1;
            end
        end
    end

endmodule

// File: tb/tb_pt2262_encoder.sv
// Scoreboard bench for pt2262_encoder: stimulus pushes the expected q per edge, a monitor pops and compares.
// Latency: each pushed expectation applies to the clock edge following the drive.
// Backpressure: n/a.
module tb_pt2262_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld  = 1'b0;
    logic [23:0] ad  = 24'hFFFFFF;
    logic        q;
`ifdef PT2262_FRAME_DONE_EN
    logic        frame_done;
`endif

    always #5 clk = ~clk;

    pt2262_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .ld         (ld),
        .ad         (ad),
        .q          (q)
`ifdef PT2262_FRAME_DONE_EN
        ,
        .frame_done (frame_done)
`endif
    );

    typedef struct {
        logic  q;
        logic  fd;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference waveform from the on-air definition, k = cycles since TX start.
    function automatic logic model_q(input logic [23:0] w, input int k);
        int         pos;
        int         c;
        int         t;
        logic [1:0] tr;
        pos = k % 512;
        if (pos >= 384) return ((pos - 384) <= 3);
        c  = pos % 32;
        t  = pos / 32;
        tr = w[(23 - 2 * t) -: 2];
        case (tr)
            2'b00:   return (c <= 3) || (c >= 16 && c <= 19);
            2'b01:   return (c <= 11) || (c >= 16 && c <= 27);
            default: return (c <= 3) || (c >= 16 && c <= 27);
        endcase
    endfunction

    task automatic drive(input logic r, input logic l, input logic [23:0] a,
                         input logic eq, input logic efd, input string tag);
        exp_t e;
        @(negedge clk);
        rst = r;
        ld  = l;
        ad  = a;
        e.q   = eq;
        e.fd  = efd;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic run_tx(input logic [23:0] shadow_w, input logic [23:0] ad_drive,
                          input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 1'b0, ad_drive, model_q(shadow_w, k), (k % 512) == 511, tag);
        end
    endtask

    // Monitor: q is presented every cycle, so one expectation is consumed per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_tests++;
                if (q !== e.q) begin
                    n_fail++;
                    $display("FAIL %s q: got %b expected %b at %0t", e.tag, q, e.q, $time);
                end
`ifdef PT2262_FRAME_DONE_EN
                n_tests++;
                if (frame_done !== e.fd) begin
                    n_fail++;
                    $display("FAIL %s frame_done: got %b expected %b at %0t", e.tag, frame_done, e.fd, $time);
                end
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with a busy-looking ad; then released without ld.
        for (int i = 0; i < 100; i++) drive(1'b1, 1'b0, 24'hFFFFFF, 1'b0, 1'b0, "reset");
        for (int i = 0; i < 20; i++)  drive(1'b0, 1'b0, 24'hFFFFFF, 1'b0, 1'b0, "post_rst");

        // All-zero word; ad changes while ld=0 must be ignored. Two full frames plus a few.
        drive(1'b0, 1'b1, 24'h000000, 1'b0, 1'b0, "ld_zero");
        drive(1'b0, 1'b1, 24'h000000, 1'b0, 1'b0, "ld_zero");
        run_tx(24'h000000, 24'hFFFFFF, 1030, "zero");

        // Mixed word: trits 0,1,0,0,0,1,1,1,1,0,F,F.
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 24'b000100000001010101001010, 1'b0, 1'b0, "ld_mixed");
        run_tx(24'b000100000001010101001010, 24'h000000, 512, "mixed");

        // Reserved code 11 in trit 11, expected identical to F.
        drive(1'b0, 1'b1, 24'h000003, 1'b0, 1'b0, "ld_reserved");
        run_tx(24'h000003, 24'h000000, 512, "reserved");

        // Abort at cycle 100 of a frame, reload with all-F.
        drive(1'b0, 1'b1, 24'h555555, 1'b0, 1'b0, "ld_ones");
        run_tx(24'h555555, 24'h555555, 100, "abort_pre");
        drive(1'b0, 1'b1, 24'hAAAAAA, 1'b0, 1'b0, "abort");
        drive(1'b0, 1'b1, 24'hAAAAAA, 1'b0, 1'b0, "abort_hold");
        run_tx(24'hAAAAAA, 24'h000000, 600, "all_f");

        // Reset mid-frame clears valid: no transmission without a fresh ld.
        drive(1'b1, 1'b0, 24'hAAAAAA, 1'b0, 1'b0, "rst_mid");
        for (int i = 0; i < 50; i++) drive(1'b0, 1'b0, 24'hAAAAAA, 1'b0, 1'b0, "after_rst");

        // Drain: the last expectation is consumed at the next edge.
        for (int i = 0; i < 4 && sb.size() > 0; i++) begin
            @(posedge clk);
            #3;
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pt2262_encoder.md
# pt2262_encoder

PT2262-compatible remote-control encoder. It serialises a 12-trit address/data word into the PT2262 on-air waveform: 12 code bits, each 32 clock cycles, followed by a 128-cycle sync bit, repeated continuously. It sits between the host register interface, which supplies `ad` and `ld`, and the RF/UART output pin `q`. One `clk` cycle equals one oscillator period (α); there is no prescaler.

## Interface
- No parameters. Fixed constants are in the package.
- `clk` input 1: single clock, rising-edge.
- `rst` input 1: reset, synchronous, active-high.
- `ld` input 1: load/hold. While high, `ad` is latched and transmission is stopped.
- `ad` input 24: 12 trits, 2 bits each. Trit 0 is `ad[23:22]`, trit 11 is `ad[1:0]`.
- `q` output 1: registered encoded waveform.

## Operation
- Trit codes:
  - 00 → "0"
  - 01 → "1"
  - 10 → "F"
  - 11 → "F" (reserved; encoded as float)
- Code-bit waveform, cycle index c = 0..31 within the bit, q = 1 when:
  - "0": c ∈ 0..3 or 16..19
  - "1": c ∈ 0..11 or 16..27
  - "F": c ∈ 0..3 or 16..27
  - q = 0 otherwise.
- Sync-bit waveform, c = 0..127: q = 1 for c ∈ 0..3, q = 0 otherwise.
- Frame: trits 0..11 in order (MSB pair first), then sync. Total 12·32 + 128 = 512 cycles. Frames repeat back-to-back while `ld` = 0.
- States:
  - IDLE: q = 0, counters held at 0.
  - TX: bit counter 0..12, where 12 = sync; cycle counter 0..31, or 0..127 during sync.
- Transitions:
  - `ld` = 1 → IDLE, `ad` captured into a shadow register, valid flag set.
  - IDLE with `ld` = 0 and valid = 1 → TX, starting trit 0 at c = 0.
  - IDLE with `ld` = 0 and valid = 0 → stays IDLE.
  - End of sync → trit 0, c = 0 (wrap). No idle gap between frames.
- `ad` changes while `ld` = 0 are ignored. Only the shadow register is transmitted.
- `ld` asserted mid-frame: the frame is aborted at the next edge, q = 0, and the new `ad` is latched. There is no partial-bit completion.
- `rst` has priority over `ld`. It clears the shadow register to 0, the valid flag to 0, the counters to 0, state to IDLE, and q to 0.

## Timing
- Reset value: q = 0, state IDLE.
- Latency: at the first edge with `ld` sampled 0 (and valid = 1), q becomes the c = 0 value of trit 0, which is always 1. q is exactly 1 cycle after that sample.
- Each trit occupies exactly 32 consecutive cycles. Sync occupies exactly 128 cycles.
- The frame period is exactly 512 cycles. q rises at cycles 0, 512, 1024… relative to TX start.
- `ld` rising: q = 0 from the following edge onward.
- `rst` mid-frame: q = 0 next edge. A fresh `ld` pulse is required before transmission restarts.

## Configuration
- `PT2262_FRAME_DONE_EN` defined: adds output `frame_done` (1 bit, registered). It pulses high for one cycle on the last sync cycle (c = 127) of every frame, and is 0 on reset and in IDLE.
- `PT2262_FRAME_DONE_EN` undefined: the port and its logic are absent. `q` behaviour is identical in both builds.

## Structure
- Package `pt2262_pkg` holds:
  - trit code constants: `TRIT_0` = 2'b00, `TRIT_1` = 2'b01, `TRIT_F` = 2'b10
  - `N_TRITS` = 12
  - `BIT_CYCLES` = 32
  - `HALF_CYCLES` = 16
  - `SHORT_HI` = 4
  - `LONG_HI` = 12
  - `SYNC_CYCLES` = 128
  - FSM state enum (IDLE, TX)
- Sub-module `pt2262_bit_wave` is natural: purely combinational.
  - Inputs: 2-bit trit, sync flag, 7-bit cycle index.
  - Output: waveform level.
  - The top holds the shadow register, counters, FSM and output register.

## Test plan
- Reset: hold `rst` = 1 with `ld` = 0 and `ad` = 24'hFFFFFF for 100 cycles → q = 0 throughout. Release `rst` without `ld` → q stays 0.
- All-zero word: pulse `ld` with `ad` = 0 → each 32-cycle bit is 4 high, 12 low, 4 high, 12 low. Sync is 4 high, 124 low. The next frame's first rising edge lands exactly 512 cycles after the first.
- Mixed word: `ad` = 24'b000100000001010101001010 → trits 0,1,0,0,0,1,1,1,1,0,F,F.
  - Trit 1 has 24 high cycles.
  - Trit 10 is high for c 0..3 and 16..27.
- Reserved code: `ad[1:0]` = 11 → trit 11 waveform identical to F.
- Abort: assert `ld` at cycle 100 of a frame with new `ad` = 24'hAAAAAA → q = 0 next edge. After `ld` falls, a fresh frame of all-F bits starts at trit 0.
- `PT2262_FRAME_DONE_EN` build: `frame_done` is high only on cycles 511, 1023… after TX start, and never while `ld` = 1.
